// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle input stream and instruction-memory write port
// The slave modport is the encoder's view; the master modport is the loader/memory side.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [3:0]        in_cond;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic              in_load;
  logic [3:0]        in_rd;
  logic [3:0]        in_rn;
  logic [3:0]        in_rm;
  logic [23:0]       in_imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_kind, in_cond, in_cmd, in_s, in_load, in_rd, in_rn, in_rm, in_imm,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport master (
    output in_valid, in_kind, in_cond, in_cmd, in_s, in_load, in_rd, in_rn, in_rm, in_imm,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded ARM-subset fields into 32-bit words for instruction memory
// One pending output word; writes go to sequential addresses until the memory is full.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   word_count,
  output logic              mem_full,
  output logic              err,
  output logic [7:0]        err_count
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] r_cnt;
  logic            r_pending;
  logic [31:0]     r_wdata;
  logic            r_err;
  logic [7:0]      r_err_count;

  logic            w_is_dp;
  logic            w_cmd_ok;
  logic            w_is_cmp;
  logic            w_s;
  logic [3:0]      w_rd;
  logic [11:0]     w_op2;
  logic [31:0]     w_word;
  logic [ADDR_W:0] w_fill;
  logic            w_accept;
  logic            w_store;
  logic            w_reject;
  logic            w_write;

  assign w_is_dp  = ~bus.in_kind[1];
  assign w_is_cmp = (bus.in_cmd == 4'b1010);

  always_comb begin
    w_cmd_ok = 1'b0;
    case (bus.in_cmd)
      4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010: w_cmd_ok = 1'b1;
      default:                                     w_cmd_ok = 1'b0;
    endcase
  end

  // CMP only sets flags, so S is forced and the destination field is zero.
  assign w_s   = w_is_cmp ? 1'b1 : bus.in_s;
  assign w_rd  = w_is_cmp ? 4'h0 : bus.in_rd;
  assign w_op2 = bus.in_kind[0] ? bus.in_imm[11:0] : {8'h00, bus.in_rm};

  always_comb begin
    w_word = 32'h0;
    case (bus.in_kind)
      2'd0, 2'd1: w_word = {bus.in_cond, 2'b00, bus.in_kind[0], bus.in_cmd, w_s,
                            bus.in_rn, w_rd, w_op2};
      2'd2:       w_word = {bus.in_cond, 2'b01, 5'b01100, bus.in_load,
                            bus.in_rn, bus.in_rd, bus.in_imm[11:0]};
      default:    w_word = {bus.in_cond, 2'b10, 2'b10, bus.in_imm};
    endcase
  end

  // Words already written plus the one waiting must leave room for a new one.
  assign w_fill       = r_cnt + {{ADDR_W{1'b0}}, r_pending};
  assign bus.in_ready = ~restart & (w_fill < DEPTH) & (~r_pending | bus.mem_ready);

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_reject = w_accept & w_is_dp & ~w_cmd_ok;
  assign w_store  = w_accept & ~(w_is_dp & ~w_cmd_ok);
  assign w_write  = r_pending & bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_wdata     <= 32'h0;
      r_err       <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_err <= w_reject;
      if (w_reject && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
      if (restart) begin
        r_cnt     <= '0;
        r_pending <= 1'b0;
      end else begin
        if (w_write)
          r_cnt <= r_cnt + 1'b1;
        if (w_store) begin
          r_pending <= 1'b1;
          r_wdata   <= w_word;
        end else if (w_write) begin
          r_pending <= 1'b0;
        end
      end
    end
  end

  assign bus.mem_we    = r_pending;
  assign bus.mem_addr  = r_cnt[ADDR_W-1:0];
  assign bus.mem_wdata = r_wdata;
  assign word_count    = r_cnt;
  assign mem_full      = r_cnt[ADDR_W];
  assign err           = r_err;
  assign err_count     = r_err_count;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
// Expected words come from an arithmetic model of the instruction format.
module tb_instr_encoder;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          restart;
  logic [AW:0]   word_count;
  logic          mem_full;
  logic          err;
  logic [7:0]    err_count;

  instr_encoder_if #(.ADDR_W(AW)) bus();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .bus        (bus),
    .word_count (word_count),
    .mem_full   (mem_full),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  int exp_err   = 0;
  logic [31:0] exp_data_q[$];
  int          exp_addr_q[$];
  logic [31:0] cap_data_q[$];
  int          cap_addr_q[$];

  // Record every write the memory actually takes, sampled mid low-phase.
  always begin
    @(negedge clk);
    #2;
    if (!reset && !restart && bus.mem_we && bus.mem_ready) begin
      cap_addr_q.push_back(int'(bus.mem_addr));
      cap_data_q.push_back(bus.mem_wdata);
    end
  end

  function automatic bit ref_supported(int cmd);
    return (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12) || (cmd == 10);
  endfunction

  function automatic logic [31:0] ref_encode(int kind, int cond, int cmd, int s, int load,
                                             int rd, int rn, int rm, int imm);
    longint w;
    int ss;
    int rdd;
    ss  = s;
    rdd = rd;
    if (kind < 2) begin
      if (cmd == 10) begin
        ss  = 1;
        rdd = 0;
      end
      w = longint'(cond) * (2**28) + kind * (2**25) + cmd * (2**21) + ss * (2**20)
          + rn * (2**16) + rdd * (2**12) + ((kind == 1) ? (imm % 4096) : rm);
    end else if (kind == 2) begin
      w = longint'(cond) * (2**28) + (2**26) + (2**24) + (2**23) + load * (2**20)
          + rn * (2**16) + rd * (2**12) + (imm % 4096);
    end else begin
      w = longint'(cond) * (2**28) + (2**27) + (2**25) + (imm % (2**24));
    end
    return w[31:0];
  endfunction

  function automatic void model_accept(int kind, int cond, int cmd, int s, int load,
                                       int rd, int rn, int rm, int imm);
    if (kind < 2 && !ref_supported(cmd)) begin
      if (exp_err < 255) exp_err++;
    end else begin
      exp_data_q.push_back(ref_encode(kind, cond, cmd, s, load, rd, rn, rm, imm));
      exp_addr_q.push_back(model_cnt % DEPTH);
      model_cnt++;
    end
  endfunction

  function automatic void model_clear();
    model_cnt = 0;
    exp_data_q.delete();
    exp_addr_q.delete();
    cap_data_q.delete();
    cap_addr_q.delete();
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input int kind, input int cond, input int cmd, input int s, input int load,
                      input int rd, input int rn, input int rm, input int imm,
                      input bit rand_rdy, output int waits);
    bit accepted;
    accepted      = 1'b0;
    waits         = 0;
    bus.in_kind   = 2'(kind);
    bus.in_cond   = 4'(cond);
    bus.in_cmd    = 4'(cmd);
    bus.in_s      = 1'(s);
    bus.in_load   = 1'(load);
    bus.in_rd     = 4'(rd);
    bus.in_rn     = 4'(rn);
    bus.in_rm     = 4'(rm);
    bus.in_imm    = 24'(imm);
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 300 && !accepted; t++) begin
      if (rand_rdy) bus.mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_ready) begin
        accepted = 1'b1;
        model_accept(kind, cond, cmd, s, load, rd, rn, rm, imm);
      end
      @(negedge clk);
      if (!accepted) waits++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready never high, got accepted=%0d required 1", accepted);
    end
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    bus.mem_ready = 1'b1;
    for (int t = 0; t < 100 && !idle; t++) begin
      #1;
      if (!bus.mem_we) idle = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL drain_timeout: mem_we=%0b required 0", bus.mem_we);
    end
    n_checks++;
    if (cap_data_q.size() != exp_data_q.size()) begin
      n_fail++;
      $display("FAIL write_count: got %0d writes required %0d", cap_data_q.size(), exp_data_q.size());
    end
    while (cap_data_q.size() > 0 && exp_data_q.size() > 0) begin
      int ca, ea;
      logic [31:0] cd, ed;
      ca = cap_addr_q.pop_front();
      ea = exp_addr_q.pop_front();
      cd = cap_data_q.pop_front();
      ed = exp_data_q.pop_front();
      n_checks++;
      if (ca != ea || cd !== ed) begin
        n_fail++;
        $display("FAIL write_word: got addr %0d data %h required addr %0d data %h", ca, cd, ea, ed);
      end
    end
    model_clear_queues_only();
    n_checks++;
    if (word_count !== (AW+1)'(model_cnt)) begin
      n_fail++;
      $display("FAIL word_count: got %0d required %0d", word_count, model_cnt);
    end
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL err_count: got %0d required %0d", err_count, exp_err);
    end
    @(negedge clk);
  endtask

  function automatic void model_clear_queues_only();
    exp_data_q.delete();
    exp_addr_q.delete();
    cap_data_q.delete();
    cap_addr_q.delete();
  endfunction

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== 32'h0 || word_count !== '0 || mem_full !== 1'b0 ||
        err !== 1'b0 || err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b we=%b addr=%0d data=%h wc=%0d full=%b err=%b ec=%0d required 1 0 0 0 0 0 0 0",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, word_count, mem_full, err, err_count);
    end
    reset = 1'b0;
    model_clear();
    exp_err = 0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int kd[5] = '{0, 1, 2, 2, 3};
    int cd[5] = '{14, 14, 14, 14, 1};
    int md[5] = '{4, 10, 0, 0, 0};
    int ld[5] = '{0, 0, 1, 0, 0};
    int rdd[5] = '{1, 7, 0, 2, 0};
    int rnd[5] = '{2, 4, 1, 3, 0};
    int rmd[5] = '{3, 0, 0, 0, 0};
    int imd[5] = '{0, 5, 8, 4, 24'hFFFFFE};
    logic [31:0] wd[5] = '{32'hE0821003, 32'hE3540005, 32'hE5910008, 32'hE5832004, 32'h1AFFFFFE};
    int waits;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(kd[i], cd[i], md[i], 0, ld[i], rdd[i], rnd[i], rmd[i], imd[i], 1'b0, waits);
      n_checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(i) || bus.mem_wdata !== wd[i] || waits != 0) begin
        n_fail++;
        $display("FAIL directed_%0d: got we=%b addr=%0d data=%h waits=%0d required we=1 addr=%0d data=%h waits=0",
                 i, bus.mem_we, bus.mem_addr, bus.mem_wdata, waits, i, wd[i]);
      end
    end
    drain();
    n_checks++;
    if (word_count !== 7'd5) begin
      n_fail++;
      $display("FAIL directed_count: got %0d required 5", word_count);
    end
  endtask

  task automatic test_reject();
    int waits;
    int cmd;
    bus.mem_ready = 1'b1;
    send(0, 14, 1, 0, 0, 1, 2, 3, 0, 1'b0, waits);
    n_checks++;
    if (err !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_pulse: got err=%b we=%b required err=1 we=0", err, bus.mem_we);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL reject_once: got err=%b err_count=%0d required err=0 err_count=1", err, err_count);
    end
    for (int i = 0; i < 299; i++) begin
      do cmd = $urandom_range(0, 15); while (ref_supported(cmd));
      send($urandom_range(0, 1), $urandom_range(0, 15), cmd, $urandom_range(0, 1), 0,
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 4095), 1'b0, waits);
    end
    @(negedge clk);
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL reject_saturate: got %0d required 255", err_count);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int waits;
    logic [31:0] ed;
    int ea;
    bus.mem_ready = 1'b0;
    send(0, $urandom_range(0, 15), 12, 1, 0, $urandom_range(0, 15), $urandom_range(0, 15),
         $urandom_range(0, 15), 0, 1'b0, waits);
    ed = exp_data_q[$];
    ea = exp_addr_q[$];
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(ea) || bus.mem_wdata !== ed || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: got we=%b addr=%0d data=%h rdy=%b required we=1 addr=%0d data=%h rdy=0",
                 i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.in_ready, ea, ed);
      end
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_random();
    int ok_cmds[5] = '{4, 2, 0, 12, 10};
    int waits;
    int cmd;
    do_restart();
    n_checks++;
    if (word_count !== '0) begin
      n_fail++;
      $display("FAIL restart_count: got %0d required 0", word_count);
    end
    for (int i = 0; i < 40; i++) begin
      cmd = ($urandom_range(0, 1) != 0) ? ok_cmds[$urandom_range(0, 4)] : $urandom_range(0, 15);
      send($urandom_range(0, 3), $urandom_range(0, 15), cmd, $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 24'hFFFFFF), 1'b1, waits);
    end
    drain();
  endtask

  task automatic test_full();
    int waits;
    do_restart();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      send(3, $urandom_range(0, 15), 0, 0, 0, 0, 0, 0, $urandom_range(0, 24'hFFFFFF), 1'b0, waits);
    drain();
    #1;
    n_checks++;
    if (mem_full !== 1'b1 || word_count !== 7'd64 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got full=%b wc=%0d rdy=%b required full=1 wc=64 rdy=0",
               mem_full, word_count, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_kind  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL full_hold_%0d: got rdy=%b we=%b required rdy=0 we=0", i, bus.in_ready, bus.mem_we);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    do_restart();
    #1;
    n_checks++;
    if (word_count !== '0 || bus.in_ready !== 1'b1 || mem_full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_restart: got wc=%0d rdy=%b full=%b required wc=0 rdy=1 full=0",
               word_count, bus.in_ready, mem_full);
    end
    @(negedge clk);
    send(2, 14, 0, 0, 1, 5, 6, 0, 12'h123, 1'b0, waits);
    n_checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'hE5965123) begin
      n_fail++;
      $display("FAIL full_rewrite: got addr=%0d data=%h required addr=0 data=e5965123", bus.mem_addr, bus.mem_wdata);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int waits;
    bus.mem_ready = 1'b0;
    send(1, 14, 4, 1, 0, 3, 4, 0, 12'hABC, 1'b0, waits);
    n_checks++;
    if (bus.mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got we=%b required 1", bus.mem_we);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== 32'h0 || word_count !== '0 || mem_full !== 1'b0 ||
        err !== 1'b0 || err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b we=%b addr=%0d data=%h wc=%0d full=%b err=%b ec=%0d required 1 0 0 0 0 0 0 0",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, word_count, mem_full, err, err_count);
    end
    model_clear();
    exp_err = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    restart       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_kind   = 2'd0;
    bus.in_cond   = 4'd0;
    bus.in_cmd    = 4'd0;
    bus.in_s      = 1'b0;
    bus.in_load   = 1'b0;
    bus.in_rd     = 4'd0;
    bus.in_rn     = 4'd0;
    bus.in_rm     = 4'd0;
    bus.in_imm    = 24'd0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_reject();
    test_backpressure();
    test_random();
    test_full();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming ARM-subset instruction encoder: accepts decoded instruction fields over a valid/ready handshake, packs them into the 32-bit word format that the core's instruction decoder consumes (cond, op, funct, Rn, Rd, operand2/offset/imm24), and writes the words sequentially into instruction memory through a backpressured write port. It sits between the program-loader/test-stimulus front end and the instruction memory. It is the exact inverse of the core decoder's field split. Unsupported ALU commands are rejected and counted, not written.

## Interface
- ADDR_W, 6, instruction-memory word-address width; depth DEPTH = 2^ADDR_W words.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- restart  in  1  synchronous clear of address, count and pending word; err_count kept.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts bundle this cycle.
- in_kind  in  2  0 = DP register, 1 = DP immediate, 2 = load/store, 3 = branch.
- in_cond  in  4  condition field.
- in_cmd  in  4  ALU command for DP kinds (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP).
- in_s  in  1  set-flags bit (DP).
- in_load  in  1  1 = LDR, 0 = STR.
- in_rd, in_rn, in_rm  in  4 each  register numbers.
- in_imm  in  24  imm12 in [11:0] for DP imm / memory, imm24 for branch.
- mem_we  out  1  write request; data/address stable while high.
- mem_ready  in  1  memory accepts write when mem_we & mem_ready.
- mem_addr  out  ADDR_W  word address of pending write.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written since reset/restart.
- mem_full  out  1  word_count == DEPTH.
- err  out  1  one-cycle pulse: rejected bundle.
- err_count  out  8  rejected bundles, saturates at 255.

## Operation
- Encoding, all kinds: [31:28] = in_cond.
- DP reg: [27:26]=00, [25]=0, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd, [11:4]=0, [3:0]=Rm.
- DP imm: as DP reg but [25]=1, [11:0]=imm[11:0].
- CMP: S forced 1, Rd field forced 0.
- Load/store: [27:26]=01, [25:20]={0,1,1,0,0,in_load}, [19:16]=Rn, [15:12]=Rd, [11:0]=imm[11:0].
- Branch: [27:26]=10, [25:24]=10, [23:0]=imm[23:0].
- DP bundle with cmd outside the five supported values: handshake completes, nothing stored, err pulses next cycle, err_count increments (saturating).
- One-entry output register (pending flag). Address counter cnt (ADDR_W+1 bits); mem_addr = cnt[ADDR_W-1:0], word_count = cnt, mem_full = cnt[ADDR_W].
- mem_we = pending. On mem_we & mem_ready: cnt increments, pending clears unless a new word is loaded the same cycle.
- in_ready = ~restart & (cnt + pending < DEPTH) & (~pending | mem_ready).
- Simultaneous write-complete and accept: new word loaded, pending stays 1, back-to-back throughput 1 word/cycle.
- restart: cnt=0, pending=0 (pending word discarded, no write); priority over handshake and write.
- Full: once cnt == DEPTH, in_ready stays 0 until restart/reset; no wrap-around.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, mem_full=0, err=0, err_count=0.
- Latency: accepted bundle at edge N -> mem_we=1 with encoded word after edge N.
- Backpressure: mem_we, mem_addr, mem_wdata held constant while mem_ready=0.
- err asserted exactly one cycle after the rejecting handshake.
- Reset mid-write: pending word lost, all outputs to reset values immediately (asynchronous).

## Test plan
- ADD cond=E, Rd=1, Rn=2, Rm=3, S=0 (kind 0) -> mem_wdata 0xE0821003 at addr 0 one cycle later; CMP imm cond=E, Rn=4, imm=5 (kind 1, S=0, Rd=7) -> 0xE3540005 at addr 1.
- LDR Rd=0, Rn=1, imm=8 -> 0xE5910008; STR Rd=2, Rn=3, imm=4 -> 0xE5832004; B cond=1, imm=0xFFFFFE -> 0x1AFFFFFE; back-to-back with mem_ready=1: one write per cycle, word_count 5.
- DP cmd=0001 -> no mem_we, err pulse 1 cycle, err_count 1; 300 rejects -> err_count 255.
- mem_ready low 3 cycles with word pending -> mem_we, addr, data stable, in_ready 0; on release write completes, count +1.
- ADDR_W=2: 4 writes -> mem_full=1, word_count=4, in_ready=0; fifth bundle held; restart -> count 0, in_ready 1, next write at addr 0.
- Assert reset while mem_we=1 and mem_ready=0 -> all outputs to reset values without waiting for clk.
